// File: rtl/uart_pkg.sv
// Shared UART constants used by the receiver and its receive FIFO.
package uart_pkg;

  localparam int UART_BYTE_W        = 8;
  localparam int UART_BAUD_DIV      = 144;
  localparam int UART_RX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receive FIFO and its neighbours.
// The receiver side drives in_data/in_stb.
// The consumer side drives rd_ready/clr_ovf and sees rd_data/rd_valid/full/overflow.
// Handshake: in_stb is a one-cycle strobe with no back-pressure, and in_data is valid only while it is high.
// On the read side a byte transfers on every posedge where rd_valid and rd_ready are both high.
// rd_valid never depends on rd_ready.
interface uart_rx_fifo_if;
  import uart_pkg::*;

  logic [UART_BYTE_W-1:0] in_data;
  logic                   in_stb;
  logic [UART_BYTE_W-1:0] rd_data;
  logic                   rd_valid;
  logic                   rd_ready;
  logic                   full;
  logic                   overflow;
  logic                   clr_ovf;

  modport master (
    output in_data, in_stb, rd_ready, clr_ovf,
    input  rd_data, rd_valid, full, overflow
  );

  modport slave (
    input  in_data, in_stb, rd_ready, clr_ovf,
    output rd_data, rd_valid, full, overflow
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver.
// It captures a byte on each receiver stop strobe, and the consumer drains it with valid/ready.
// A sticky overflow flag records dropped bytes.
// Optional build macro UART_RX_FIFO_LEVEL_EN adds a 'level' output that mirrors the occupancy count.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  uart_rx_fifo_if.slave    bus
`ifdef UART_RX_FIFO_LEVEL_EN
  ,
  output logic [AW:0]      level
`endif
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [UART_BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count;
  logic                   ovf_q;

  logic rd_fire;
  logic wr_en;
  logic drop;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a byte while it is being read.
  always_comb begin
    rd_fire = 1'b0;
    wr_en   = 1'b0;
    drop    = 1'b0;
    rd_fire = (count != '0) && bus.rd_ready;
    wr_en   = bus.in_stb && ((count != DEPTH_C) || rd_fire);
    drop    = bus.in_stb && (count == DEPTH_C) && !rd_fire;
  end

  // Storage write; the array is not cleared by reset, and a strobe in the reset cycle is ignored.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // Pointers and occupancy count; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)   wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, rd_fire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  // Head of queue is presented combinationally from the registered read pointer.
  // It reads as zero when the FIFO is empty.
  always_comb begin
    bus.rd_valid = (count != '0);
    bus.rd_data  = bus.rd_valid ? mem[rd_ptr] : '0;
    bus.full     = (count == DEPTH_C);
    bus.overflow = ovf_q;
  end

`ifdef UART_RX_FIFO_LEVEL_EN
  // Occupancy as seen by software; it is the count register itself.
  always_comb begin
    level = count;
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
// Expected values are hand-derived or come from a byte queue model.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk;
  logic reset;
  uart_rx_fifo_if bus ();
`ifdef UART_RX_FIFO_LEVEL_EN
  logic [AW:0] level;
`endif

  int n_total;
  int n_pass;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef UART_RX_FIFO_LEVEL_EN
    ,
    .level (level)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: apply one cycle of inputs, then sample #1 after the edge.
  task automatic cycle(input logic stb, input logic [7:0] d, input logic rdy, input logic clr);
    bus.in_stb   = stb;
    bus.in_data  = d;
    bus.rd_ready = rdy;
    bus.clr_ovf  = clr;
    @(posedge clk);
    #1;
    bus.in_stb   = 1'b0;
    bus.in_data  = 8'h00;
    bus.rd_ready = 1'b0;
    bus.clr_ovf  = 1'b0;
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, base + 8'(i), 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.rd_valid); else n_pass++;
    n_total++; if (bus.full !== 1'b0) $display("FAIL reset_full got %b want 0", bus.full); else n_pass++;
    n_total++; if (bus.rd_data !== 8'h00) $display("FAIL reset_data got %h want 00", bus.rd_data); else n_pass++;
    n_total++; if (bus.overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus.overflow); else n_pass++;
  endtask

  task automatic test_single();
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    n_total++; if (bus.rd_valid !== 1'b1) $display("FAIL single_valid got %b want 1", bus.rd_valid); else n_pass++;
    n_total++; if (bus.rd_data !== 8'hA5) $display("FAIL single_data got %h want a5", bus.rd_data); else n_pass++;
`ifdef UART_RX_FIFO_LEVEL_EN
    n_total++; if (level !== 5'd1) $display("FAIL single_level got %0d want 1", level); else n_pass++;
`endif
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL single_pop_valid got %b want 0", bus.rd_valid); else n_pass++;
    n_total++; if (bus.rd_data !== 8'h00) $display("FAIL single_pop_data got %h want 00", bus.rd_data); else n_pass++;
    // rd_ready while empty has no effect
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL empty_ready_valid got %b want 0", bus.rd_valid); else n_pass++;
    // empty with strobe and ready: only the write happens
    cycle(1'b1, 8'h6B, 1'b1, 1'b0);
    n_total++; if (bus.rd_data !== 8'h6B || bus.rd_valid !== 1'b1)
      $display("FAIL empty_rw got %b/%h want 1/6b", bus.rd_valid, bus.rd_data); else n_pass++;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_fill_order();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == DEPTH - 2) begin
        n_total++; if (bus.full !== 1'b0) $display("FAIL fill_15_full got %b want 0", bus.full); else n_pass++;
      end
    end
    n_total++; if (bus.full !== 1'b1) $display("FAIL fill_16_full got %b want 1", bus.full); else n_pass++;
`ifdef UART_RX_FIFO_LEVEL_EN
    n_total++; if (level !== 5'd16) $display("FAIL fill_level got %0d want 16", level); else n_pass++;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      n_total++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'(i))
        $display("FAIL drain_%0d got %b/%h want 1/%h", i, bus.rd_valid, bus.rd_data, 8'(i));
      else n_pass++;
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL drain_empty got %b want 0", bus.rd_valid); else n_pass++;
  endtask

  task automatic test_overflow();
    fill(8'h10);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    n_total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", bus.overflow); else n_pass++;
    n_total++; if (bus.full !== 1'b1) $display("FAIL ovf_full got %b want 1", bus.full); else n_pass++;
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_total++; if (bus.overflow !== 1'b0) $display("FAIL ovf_clr got %b want 0", bus.overflow); else n_pass++;
    cycle(1'b1, 8'hFE, 1'b0, 1'b1);
    n_total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_set_wins got %b want 1", bus.overflow); else n_pass++;
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      n_total++;
      if (bus.rd_data !== 8'h10 + 8'(i)) $display("FAIL ovf_drain_%0d got %h want %h", i, bus.rd_data, 8'h10 + 8'(i));
      else n_pass++;
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL ovf_drain_empty got %b want 0", bus.rd_valid); else n_pass++;
  endtask

  task automatic test_full_concurrent();
    fill(8'h20);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    n_total++; if (bus.full !== 1'b1) $display("FAIL fullrw_full got %b want 1", bus.full); else n_pass++;
    n_total++; if (bus.overflow !== 1'b0) $display("FAIL fullrw_ovf got %b want 0", bus.overflow); else n_pass++;
    for (int i = 1; i <= DEPTH; i++) begin
      logic [7:0] want;
      want = (i == DEPTH) ? 8'h55 : 8'h20 + 8'(i);
      n_total++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== want)
        $display("FAIL fullrw_drain_%0d got %b/%h want 1/%h", i, bus.rd_valid, bus.rd_data, want);
      else n_pass++;
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL fullrw_empty got %b want 0", bus.rd_valid); else n_pass++;
  endtask

  // Scoreboard: expected queue of bytes in order.
  task automatic test_wrap();
    exp_q.delete();
    for (int k = 0; k < 40; k++) begin
      logic [7:0] d;
      logic       rdy;
      logic       popped;
      d      = 8'h40 + 8'(k * 5);
      rdy    = (k % 3) != 0;
      popped = 1'b0;
      if (rdy && exp_q.size() != 0) begin
        n_total++;
        if (bus.rd_data !== exp_q[0]) $display("FAIL wrap_data_%0d got %h want %h", k, bus.rd_data, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
        popped = 1'b1;
      end
      if (exp_q.size() < DEPTH || popped) exp_q.push_back(d);
      cycle(1'b1, d, rdy, 1'b0);
      n_total++;
      if (bus.rd_valid !== (exp_q.size() != 0) || bus.full !== (exp_q.size() == DEPTH))
        $display("FAIL wrap_flags_%0d got %b%b want %b%b", k, bus.rd_valid, bus.full,
                 exp_q.size() != 0, exp_q.size() == DEPTH);
      else n_pass++;
`ifdef UART_RX_FIFO_LEVEL_EN
      n_total++; if (level !== 5'(exp_q.size())) $display("FAIL wrap_level_%0d got %0d want %0d", k, level, exp_q.size()); else n_pass++;
`endif
    end
    while (exp_q.size() != 0) begin
      n_total++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_q[0])
        $display("FAIL wrap_drain got %b/%h want 1/%h", bus.rd_valid, bus.rd_data, exp_q[0]);
      else n_pass++;
      void'(exp_q.pop_front());
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    n_total++; if (bus.overflow !== 1'b0) $display("FAIL wrap_ovf got %b want 0", bus.overflow); else n_pass++;
  endtask

  task automatic test_reset_mid();
    fill(8'h90);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    n_total++; if (bus.overflow !== 1'b1) $display("FAIL mid_pre_ovf got %b want 1", bus.overflow); else n_pass++;
    reset = 1'b1;
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    reset = 1'b0;
    n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL mid_valid got %b want 0", bus.rd_valid); else n_pass++;
    n_total++; if (bus.overflow !== 1'b0) $display("FAIL mid_ovf got %b want 0", bus.overflow); else n_pass++;
    n_total++; if (bus.full !== 1'b0) $display("FAIL mid_full got %b want 0", bus.full); else n_pass++;
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    n_total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h3C)
      $display("FAIL mid_head got %b/%h want 1/3c", bus.rd_valid, bus.rd_data); else n_pass++;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL mid_after got %b want 0", bus.rd_valid); else n_pass++;
  endtask

  initial begin
    n_total      = 0;
    n_pass       = 0;
    reset        = 1'b1;
    bus.in_stb   = 1'b0;
    bus.in_data  = 8'h00;
    bus.rd_ready = 1'b0;
    bus.clr_ovf  = 1'b0;
    test_reset();
    test_single();
    test_fill_order();
    test_overflow();
    test_full_concurrent();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
